// File: rtl/eight_bit_alu_executor_if.sv
// Operand/opcode request and result/status return between the 8-bit control unit and its ALU executor.
// The control unit is the master; the executor is the slave.
interface eight_bit_alu_executor_if;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] op_in;
  logic       enable_alu;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       busy;
  logic       done;
  logic       carry;
  logic       zero;
  logic       ovf;
  logic       div_zero;
  logic       illegal_op;

  modport master (
    output a_in, b_in, op_in, enable_alu,
    input  result, result_hi, busy, done, carry, zero, ovf, div_zero, illegal_op
  );

  modport slave (
    input  a_in, b_in, op_in, enable_alu,
    output result, result_hi, busy, done, carry, zero, ovf, div_zero, illegal_op
  );
endinterface

// File: rtl/eight_bit_alu_executor.sv
// 8-bit ALU executor: single-cycle add/sub/shift, 8-iteration shift-add multiply/square
// and restoring divide, with registered result, upper byte, status flags and done pulse.
module eight_bit_alu_executor #(
  parameter logic [7:0] DIV_ZERO_VAL = 8'hFF,
  parameter int         SHAMT_BITS   = 3
) (
  input  logic clk,
  input  logic rst_n,
  eight_bit_alu_executor_if.slave alu
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SQA = 4'd6;
  localparam logic [3:0] OP_SQB = 4'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] iter_cnt;
  logic [7:0] a_lat, b_lat;
  logic [3:0] op_lat;
  logic [7:0] work_hi, work_lo;

  // Returns {carry, result}; carry is the last bit shifted out, 0 for a zero shift.
  function automatic logic [8:0] shl_carry(input logic [7:0] a, input logic [SHAMT_BITS-1:0] s);
    logic [8:0] t;
    t = {1'b0, a} << s;
    return t;
  endfunction

  function automatic logic [8:0] shr_carry(input logic [7:0] a, input logic [SHAMT_BITS-1:0] s);
    logic [8:0] t;
    t = {a, 1'b0} >> s;
    return {t[0], t[8:1]};
  endfunction

  logic [7:0] sc_res, sc_hi;
  logic       sc_carry, sc_dz, sc_ill, sc_iter;

  always_comb begin
    sc_res   = 8'd0;
    sc_hi    = 8'd0;
    sc_carry = 1'b0;
    sc_dz    = 1'b0;
    sc_ill   = 1'b0;
    sc_iter  = 1'b0;
    case (alu.op_in)
      OP_ADD: {sc_carry, sc_res} = {1'b0, alu.a_in} + {1'b0, alu.b_in};
      OP_SUB: begin
        sc_res   = alu.a_in - alu.b_in;
        sc_carry = (alu.a_in < alu.b_in);
      end
      OP_SHL: {sc_carry, sc_res} = shl_carry(alu.a_in, alu.b_in[SHAMT_BITS-1:0]);
      OP_SHR: {sc_carry, sc_res} = shr_carry(alu.a_in, alu.b_in[SHAMT_BITS-1:0]);
      OP_DIV: begin
        if (alu.b_in == 8'd0) begin
          sc_res = DIV_ZERO_VAL;
          sc_hi  = alu.a_in;
          sc_dz  = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      OP_MUL, OP_SQA, OP_SQB: sc_iter = 1'b1;
      default: sc_ill = 1'b1;
    endcase
  end

  // Iteration step: {work_hi, work_lo} is the product (hi:lo) or remainder:quotient pair.
  logic [7:0] mcand;
  logic [8:0] mul_sum, div_shift, div_diff;
  logic       div_ge;
  logic [7:0] step_hi, step_lo;

  always_comb begin
    mcand     = (op_lat == OP_SQA) ? a_lat : b_lat;
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : 9'd0);
    div_shift = {work_hi, work_lo[7]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_diff  = div_shift - {1'b0, mcand};
    if (op_lat == OP_DIV) begin
      step_hi = div_ge ? div_diff[7:0] : div_shift[7:0];
      step_lo = {work_lo[6:0], div_ge};
    end else begin
      step_hi = mul_sum[8:1];
      step_lo = {mul_sum[0], work_lo[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (alu.enable_alu) state_nxt = sc_iter ? CALC : DONE;
      CALC: if (iter_cnt == 3'd7) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign alu.busy = (state == CALC);
  assign alu.done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt       <= 3'd0;
      a_lat          <= 8'd0;
      b_lat          <= 8'd0;
      op_lat         <= 4'd0;
      work_hi        <= 8'd0;
      work_lo        <= 8'd0;
      alu.result     <= 8'd0;
      alu.result_hi  <= 8'd0;
      alu.carry      <= 1'b0;
      alu.zero       <= 1'b0;
      alu.ovf        <= 1'b0;
      alu.div_zero   <= 1'b0;
      alu.illegal_op <= 1'b0;
    end else if (state == IDLE && alu.enable_alu) begin
      a_lat    <= alu.a_in;
      b_lat    <= alu.b_in;
      op_lat   <= alu.op_in;
      iter_cnt <= 3'd0;
      work_hi  <= 8'd0;
      work_lo  <= (alu.op_in == OP_SQB) ? alu.b_in : alu.a_in;
      if (!sc_iter) begin
        alu.result     <= sc_res;
        alu.result_hi  <= sc_hi;
        alu.carry      <= sc_carry;
        alu.zero       <= (sc_res == 8'd0);
        alu.ovf        <= 1'b0;
        alu.div_zero   <= sc_dz;
        alu.illegal_op <= sc_ill;
      end
    end else if (state == CALC) begin
      work_hi  <= step_hi;
      work_lo  <= step_lo;
      iter_cnt <= iter_cnt + 3'd1;
      if (iter_cnt == 3'd7) begin
        alu.result     <= step_lo;
        alu.result_hi  <= step_hi;
        alu.carry      <= 1'b0;
        alu.zero       <= (step_lo == 8'd0);
        alu.ovf        <= (op_lat != OP_DIV) && (step_hi != 8'd0);
        alu.div_zero   <= 1'b0;
        alu.illegal_op <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eight_bit_alu_executor.sv
// Directed bench for eight_bit_alu_executor: vector table plus hand-written
// back-to-back and mid-operation reset sequences.
module tb_eight_bit_alu_executor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eight_bit_alu_executor_if bus();

  eight_bit_alu_executor #(.DIV_ZERO_VAL(8'hFF), .SHAMT_BITS(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .alu  (bus.slave)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] flags; // {carry, zero, ovf, div_zero, illegal_op}
    int         lat;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt, output bit got);
    @(negedge clk);
    bus.op_in = op;
    bus.a_in = a;
    bus.b_in = b;
    bus.enable_alu = 1'b1;
    lat = 0;
    bcnt = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk);
      #1;
      bus.enable_alu = 1'b0;
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) got = 1'b1;
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {bus.carry, bus.zero, bus.ovf, bus.div_zero, bus.illegal_op};
  endfunction

  function automatic logic [31:0] all_outs();
    return {bus.result, bus.result_hi, 9'd0, bus.busy, bus.done, flags_now()};
  endfunction

  int  lat, bcnt, dcnt;
  bit  got;

  initial begin
    vecs[0]  = '{4'd0,  8'd200, 8'd100, 8'd44,  8'd0,   5'b10000, 1};
    vecs[1]  = '{4'd0,  8'd255, 8'd1,   8'd0,   8'd0,   5'b11000, 1};
    vecs[2]  = '{4'd1,  8'd0,   8'd1,   8'd255, 8'd0,   5'b10000, 1};
    vecs[3]  = '{4'd1,  8'd5,   8'd5,   8'd0,   8'd0,   5'b01000, 1};
    vecs[4]  = '{4'd2,  8'd200, 8'd3,   8'h58,  8'h02,  5'b00100, 9};
    vecs[5]  = '{4'd7,  8'd99,  8'd15,  8'd225, 8'd0,   5'b00000, 9};
    vecs[6]  = '{4'd2,  8'd255, 8'd255, 8'h01,  8'hFE,  5'b00100, 9};
    vecs[7]  = '{4'd6,  8'd16,  8'd0,   8'd0,   8'd1,   5'b01100, 9};
    vecs[8]  = '{4'd3,  8'd100, 8'd7,   8'd14,  8'd2,   5'b00000, 9};
    vecs[9]  = '{4'd3,  8'd9,   8'd0,   8'hFF,  8'd9,   5'b00010, 1};
    vecs[10] = '{4'd3,  8'd7,   8'd200, 8'd0,   8'd7,   5'b01000, 9};
    vecs[11] = '{4'd4,  8'h81,  8'd1,   8'h02,  8'd0,   5'b10000, 1};
    vecs[12] = '{4'd5,  8'h81,  8'd8,   8'h81,  8'd0,   5'b00000, 1};
    vecs[13] = '{4'd5,  8'h81,  8'd1,   8'h40,  8'd0,   5'b10000, 1};
    vecs[14] = '{4'd4,  8'h81,  8'd7,   8'h80,  8'd0,   5'b00000, 1};
    vecs[15] = '{4'd11, 8'd0,   8'd0,   8'd0,   8'd0,   5'b01001, 1};

    bus.a_in = 8'd0;
    bus.b_in = 8'd0;
    bus.op_in = 4'd0;
    bus.enable_alu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, got);
      if (!got) begin
        errors++;
        checks++;
        $display("FAIL v%0d_timeout: no done within 30 cycles", i);
      end else begin
        chk($sformatf("v%0d_result", i), {24'd0, bus.result}, {24'd0, vecs[i].res});
        chk($sformatf("v%0d_result_hi", i), {24'd0, bus.result_hi}, {24'd0, vecs[i].hi});
        chk($sformatf("v%0d_flags", i), {27'd0, flags_now()}, {27'd0, vecs[i].flags});
        chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        chk($sformatf("v%0d_busy_cycles", i), bcnt, (vecs[i].lat == 9) ? 8 : 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse_len", i), {31'd0, bus.done}, 32'd0);
      end
    end

    // enable held high; operands changed mid-CALC must not affect the multiply
    @(negedge clk);
    bus.op_in = 4'd2;
    bus.a_in = 8'd3;
    bus.b_in = 8'd4;
    bus.enable_alu = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_busy_after_accept", {31'd0, bus.busy}, 32'd1);
    bus.op_in = 4'd0;
    bus.a_in = 8'd10;
    bus.b_in = 8'd20;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) got = 1'b1;
    end
    chk("hold_mul_done_seen", {31'd0, got}, 32'd1);
    chk("hold_mul_result", {24'd0, bus.result}, 32'd12);
    @(posedge clk);
    #1;
    chk("hold_idle_gap", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_add_done", {31'd0, bus.done}, 32'd1);
    chk("hold_add_result", {24'd0, bus.result}, 32'd30);
    bus.enable_alu = 1'b0;
    dcnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    chk("hold_no_extra_done", dcnt, 0);

    // asynchronous reset during the fourth multiply iteration
    @(negedge clk);
    bus.op_in = 4'd2;
    bus.a_in = 8'd200;
    bus.b_in = 8'd3;
    bus.enable_alu = 1'b1;
    @(posedge clk);
    #1;
    bus.enable_alu = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", all_outs(), 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("rst_no_done", dcnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd0, 8'd1, 8'd1, lat, bcnt, got);
    chk("post_rst_done_seen", {31'd0, got}, 32'd1);
    chk("post_rst_result", {24'd0, bus.result}, 32'd2);
    chk("post_rst_latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eight_bit_alu_executor.md
Name: eight_bit_alu_executor

Overview:
- Execution-side responder for the 8-bit control unit.
- Samples the control unit's operand, opcode and ALU-enable outputs, then performs the operation.
- Single-cycle ops (add, sub, shifts) finish in 1 cycle; multiply, divide and square use an 8-iteration shift-add/restoring sequencer.
- Returns a registered 8-bit result, an upper byte, status flags and a one-cycle done pulse; `result` feeds the control unit's `alu_in`.

Parameters:
- DIV_ZERO_VAL, 8'hFF, value driven on `result` when the divisor is zero.
- SHAMT_BITS, 3, number of low bits of `b_in` used as the shift amount.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_in  input  8  operand A (control unit `a_out`).
- b_in  input  8  operand B (control unit `b_out`).
- op_in  input  4  opcode (control unit `instruction_out`).
- enable_alu  input  1  level request from the control unit.
- result  output  8  low result byte (to control unit `alu_in`).
- result_hi  output  8  product high byte / division remainder / 0.
- busy  output  1  high while an operation is in flight (CALC state).
- done  output  1  one-cycle pulse; `result` and flags are valid from this cycle.
- carry  output  1  add carry-out / sub borrow.
- zero  output  1  `result == 0`.
- ovf  output  1  mul/square: `result_hi != 0`.
- div_zero  output  1  divide with `b == 0`.
- illegal_op  output  1  opcode 8..15 received.

Behaviour:
- Reset: already decided — one clock, `clk`; reset `rst_n` is asynchronous, active-low. On assertion (including mid-operation):
  - state goes to IDLE, iteration counter = 0;
  - every output = 0, operand/opcode latches = 0.
  - An in-flight op is abandoned; no done pulse is issued.
- States: IDLE, CALC, DONE.
- Accept rule:
  - At a rising edge in IDLE with `enable_alu == 1`, latch `a_in`, `b_in` and `op_in`.
  - `enable_alu` is ignored in CALC and DONE; no queuing.
  - `enable_alu` is a level. If it is still high in IDLE after DONE, a new op is accepted; max throughput is 1 op per 2 cycles (single-cycle ops).
- Single-cycle ops (accept edge N → DONE, result registered at edge N; done high for cycle N..N+1; back to IDLE at edge N+1):
  - 0 add: `{carry, result} = a + b`; `result_hi = 0`.
  - 1 sub: `result = a - b` mod 256; `carry = (a < b)`.
  - 4 shl: `result = a << b[SHAMT_BITS-1:0]`; `carry` = last bit shifted out (0 if shift amount is 0).
  - 5 shr: logical; `result = a >> b[SHAMT_BITS-1:0]`; `carry` as for shl.
  - 3 div with `b == 0`: `result = DIV_ZERO_VAL`, `result_hi = a`, `div_zero = 1`.
  - 8..15: `result = 0`, `result_hi = 0`, `illegal_op = 1`.
- Iterative ops (accept edge N → CALC, counter = 0; one iteration per edge at N+1..N+8; counter == 7 at an edge → DONE with final result; done high after edge N+8; IDLE at edge N+9):
  - 2 mul: a×b.
  - 6 square a: a×a.
  - 7 square b: b×b.
  - For all three: 16-bit product, `result = product[7:0]`, `result_hi = product[15:8]`, `ovf = (result_hi != 0)`.
  - 3 div: restoring, unsigned; `result` = quotient, `result_hi` = remainder.
  - `busy = 1` exactly during CALC (8 cycles).
- Output hold:
  - `result`, `result_hi` and all flags update only on entry to DONE.
  - They hold their value until the next DONE entry or reset.
  - Flags not defined for an op are cleared at that op's DONE entry.
  - `zero` is computed from the new `result`.
- Boundary conditions:
  - 255+1 → result 0, carry 1, zero 1.
  - 0−1 → result 255, carry 1.
  - Shift amount 0 → result = a.
  - 255×255 → 0xFE01.
  - Input changes during CALC have no effect, because operands are latched at accept.
  - `enable_alu` rising in the same cycle as reset release: not accepted until the first edge with `rst_n` high.

Test Plan:
- add a=200, b=100, enable for 1 cycle → done 1 cycle after accept; result=44, carry=1, zero=0, busy never high.
- mul a=200, b=3 → busy high 8 cycles; done after edge N+8; result=0x58, result_hi=0x02, ovf=1. Then square b with b=15 → result=225, ovf=0.
- div a=100, b=7 → 8-cycle latency; result=14, result_hi=2. div a=9, b=0 → 1-cycle latency; result=0xFF, result_hi=9, div_zero=1.
- shl a=0x81, b=1 → result=0x02, carry=1. shr a=0x81, b=8 (shift amount 0) → result=0x81, carry=0. op=4'b1011 → illegal_op=1, result=0.
- Hold `enable_alu` high continuously with alternating ops → each op accepted only in IDLE; exactly one done pulse per op; operand changes mid-CALC ignored.
- Assert `rst_n` low at CALC iteration 4 of a mul → all outputs 0 immediately (asynchronously); no done pulse; after release, the next add 1+1 gives result=2.
